score_display: RTL

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/score_display.sv
// rtl/score_display.sv - binary score to BCD converter with multiplexed 7-segment scan
// Double-dabble conversion runs one score bit per cycle; the scan shows the last converted value.
module score_display #(
  parameter int SCORE_W     = 10,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [SCORE_W-1:0]    score,
  input  logic                  load,
  input  logic [3:0]            pattern,
  input  logic                  C,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic [7:0]            LED,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  ovf
);

  // One spare nibble over the log10(2) estimate keeps wide scores safe.
  localparam int BCD_N = (SCORE_W * 3) / 10 + 2;
  localparam int ND    = (BCD_N > DIGITS) ? BCD_N : DIGITS;
  localparam int BW    = 4 * ND;
  localparam int CW    = $clog2(SCORE_W + 1);
  localparam int RW    = $clog2(REFRESH_DIV);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t               state, state_nxt;
  logic                 start, done, over;
  logic [SCORE_W-1:0]   sr;
  logic [BW-1:0]        acc, acc_adj, acc_nxt;
  logic [CW-1:0]        bitcnt;
  logic [4*DIGITS-1:0]  bcd_res;

  logic [RW-1:0]        rcnt;
  logic [IW-1:0]        idx;
  logic [3:0]           nib;
  logic [DIGITS-1:0]    zhi;
  logic                 blank;
  logic [7:0]           seg_dec;
  logic [DIGITS-1:0]    an_dec;
  logic [4:0]           led_lo;

  always_ff @(posedge clk) begin
    if (!res) state <= IDLE;
    else      state <= state_nxt;
  end

  // A load arriving in the final CONV cycle is dropped since only IDLE accepts it.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (load) begin
        start     = 1'b1;
        state_nxt = CONV;
      end
      CONV: if (bitcnt == CW'(SCORE_W - 1)) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < ND; i++) begin
      acc_adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end
    acc_nxt = {acc_adj[BW-2:0], sr[SCORE_W-1]};
    over    = (acc_nxt >> (4 * DIGITS)) != '0;
    bcd_res = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_res[4*i +: 4] = over ? 4'h9 : acc_nxt[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      sr     <= '0;
      acc    <= '0;
      bitcnt <= '0;
      bcd    <= '0;
      ovf    <= 1'b0;
    end else if (start) begin
      sr     <= score;
      acc    <= '0;
      bitcnt <= '0;
    end else if (state == CONV) begin
      sr     <= sr << 1;
      acc    <= acc_nxt;
      bitcnt <= bitcnt + CW'(1);
      if (done) begin
        bcd <= bcd_res;
        ovf <= over;
      end
    end
  end

  assign busy = (state == CONV);

  always_ff @(posedge clk) begin
    if (!res) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  // zhi[i]: nibble i and every nibble above it are zero.
  always_comb begin
    zhi = '0;
    zhi[DIGITS-1] = (bcd[4*DIGITS-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zhi[i] = zhi[i+1] && (bcd[4*i +: 4] == 4'd0);
    end
    nib   = bcd[{idx, 2'b00} +: 4];
    blank = (BLANK_LZ != 0) && (idx != '0) && zhi[idx];
    case (nib)
      4'd0:    seg_dec = 8'hC0;
      4'd1:    seg_dec = 8'hF9;
      4'd2:    seg_dec = 8'hA4;
      4'd3:    seg_dec = 8'hB0;
      4'd4:    seg_dec = 8'h99;
      4'd5:    seg_dec = 8'h92;
      4'd6:    seg_dec = 8'h82;
      4'd7:    seg_dec = 8'hF8;
      4'd8:    seg_dec = 8'h80;
      4'd9:    seg_dec = 8'h90;
      default: seg_dec = 8'hFF;
    endcase
    an_dec = '1;
    if (C) an_dec[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      SEG    <= 8'hFF;
      AN     <= '1;
      led_lo <= '0;
    end else begin
      SEG    <= blank ? 8'hFF : seg_dec;
      AN     <= an_dec;
      led_lo <= {C, pattern};
    end
  end

  assign LED = {ovf, busy, 1'b0, led_lo};

endmodule
